// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message schedule datapath.
package sha256_pkg;

    localparam int WORDS  = 16;
    localparam int ROUNDS = 64;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/low_sigma_0_func.sv
// SHA-256 small sigma 0: ROTR7 ^ ROTR18 ^ SHR3.
// Purely combinational, no latency, no flow control.
module low_sigma_0_func
    import sha256_pkg::*;
(
    input  word_t i_x,
    output word_t o_y
);

    assign o_y = {i_x[6:0],  i_x[31:7]}
               ^ {i_x[17:0], i_x[31:18]}
               ^ {3'b000,    i_x[31:3]};

endmodule

// File: rtl/low_sigma_1_func.sv
// SHA-256 small sigma 1: ROTR17 ^ ROTR19 ^ SHR10.
// Purely combinational, no latency, no flow control.
module low_sigma_1_func
    import sha256_pkg::*;
(
    input  word_t i_x,
    output word_t o_y
);

    assign o_y = {i_x[16:0], i_x[31:17]}
               ^ {i_x[18:0], i_x[31:19]}
               ^ {10'd0,     i_x[31:10]};

endmodule

// File: rtl/sha256_msg_sched.sv
// Loads 16 message words, then streams W[0..63] using a 16-entry rolling buffer.
// W[0] one cycle after the 16th input; 1 word/cycle, holds output while out_ready is low.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [3:0]   r_cnt;
    logic [5:0]   r_t;
    word_t        r_buf [WORDS];

    logic         w_in_hs;
    logic         w_out_hs;
    logic [3:0]   w_slot;
    word_t        w_s0;
    word_t        w_s1;
    word_t        w_sched;
    word_t        w_out_word;

    assign w_in_hs  = in_valid  & in_ready;
    assign w_out_hs = out_valid & out_ready;
    assign w_slot   = r_t[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_in_hs && r_cnt == 4'd15) w_state_nxt = ST_EMIT;
            ST_EMIT: if (w_out_hs && r_t == LAST_T) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_LOAD);
        out_valid = (r_state == ST_EMIT);
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
            r_t   <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_cnt <= 4'd0;
                    r_t   <= 6'd0;
                end
                ST_LOAD: if (w_in_hs) begin
                    r_cnt <= r_cnt + 4'd1;
                    r_t   <= 6'd0;
                end
                ST_EMIT: if (w_out_hs) r_t <= r_t + 6'd1;
                default: ;
            endcase
        end
    end

    // Slot t%16 holds W[t-16] until it is overwritten by W[t] on the handshake.
    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD && w_in_hs)
            r_buf[r_cnt] <= in_word;
        else if (r_state == ST_EMIT && w_out_hs && r_t[5:4] != 2'b00)
            r_buf[w_slot] <= w_sched;
    end

    low_sigma_0_func u_s0 (
        .i_x (r_buf[4'(w_slot + 4'd1)]),
        .o_y (w_s0)
    );

    low_sigma_1_func u_s1 (
        .i_x (r_buf[4'(w_slot - 4'd2)]),
        .o_y (w_s1)
    );

    assign w_sched = w_s1 + r_buf[4'(w_slot + 4'd9)] + w_s0 + r_buf[w_slot];

    always_comb begin
        w_out_word = '0;
        if (out_valid)
            w_out_word = (r_t[5:4] == 2'b00) ? r_buf[w_slot] : w_sched;
    end

    assign out_word = w_out_word;
    assign out_idx  = out_valid ? r_t : 6'd0;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Randomized bench for sha256_msg_sched against an array-based schedule model.
module tb_sha256_msg_sched;
    import sha256_pkg::*;

    typedef logic [31:0] w16_t [16];
    typedef logic [31:0] w64_t [64];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    sha256_msg_sched #(.ROUNDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic w64_t ref_sched(input w16_t m);
        w64_t w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
                      + w[t-7]
                      + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                      + w[t-16];
        end
        return w;
    endfunction

    // gap_mode: 0 = in_valid always high, 1 = toggle starting with 1, 2 = random
    task automatic load_block(input w16_t m, input int gap_mode, input bit poke);
        int i = 0;
        int cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("load_in_ready", 32'(in_ready), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        while (i < 16) begin
            if (cyc > 300) begin
                chk("load_timeout", 32'(i), 32'd16);
                return;
            end
            case (gap_mode)
                1:       in_valid = (cyc % 2 == 0);
                2:       in_valid = ($urandom_range(0, 2) != 0);
                default: in_valid = 1'b1;
            endcase
            in_word = in_valid ? m[i] : $urandom;
            start   = poke && (i == 5);
            if (in_valid && in_ready) i++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("w0_latency", 32'(out_valid), 32'd1);
    endtask

    task automatic emit_block(input w64_t exp, input int stall_at, input bit rand_rdy,
                              input bit poke, input int abort_at, output w64_t got);
        int t = 0;
        int stall = 0;
        int cyc = 0;
        for (int k = 0; k < 64; k++) got[k] = 32'd0;
        while (t < 64) begin
            if (t == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_out_valid", 32'(out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_out_word", out_word, 32'd0);
                chk("abort_out_idx", 32'(out_idx), 32'd0);
                out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (cyc > 600) begin
                chk("emit_timeout", 32'(t), 32'd64);
                return;
            end
            if (t == stall_at && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            start    = poke && (t == 40);
            in_valid = poke;
            in_word  = $urandom;
            chk("emit_out_valid", 32'(out_valid), 32'd1);
            chk($sformatf("out_idx[%0d]", t), 32'(out_idx), 32'(t));
            chk($sformatf("W[%0d]", t), out_word, exp[t]);
            if (out_ready) begin
                got[t] = out_word;
                t++;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("done_drop", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_out_word", out_word, 32'd0);
    endtask

    w16_t m_abc, m_zero, m_rnd;
    w64_t e_abc, e_rnd, got;

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_abc[i]  = 32'd0;
            m_zero[i] = 32'd0;
        end
        m_abc[0]  = 32'h61626380;
        m_abc[15] = 32'h00000018;
        e_abc = ref_sched(m_abc);

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_busy_hold", 32'(busy), 32'd0);
        in_valid = 1'b0;

        load_block(m_abc, 0, 1'b0);
        emit_block(e_abc, -1, 1'b0, 1'b0, -1, got);
        chk("abc_W0", got[0], 32'h61626380);
        chk("abc_W15", got[15], 32'h00000018);
        chk("abc_W16", got[16], 32'h61626380);
        chk("abc_W17", got[17], 32'h000F0000);

        load_block(m_zero, 0, 1'b0);
        emit_block(ref_sched(m_zero), -1, 1'b0, 1'b0, -1, got);

        load_block(m_abc, 0, 1'b0);
        emit_block(e_abc, 20, 1'b0, 1'b0, -1, got);

        for (int i = 0; i < 16; i++) m_rnd[i] = $urandom;
        e_rnd = ref_sched(m_rnd);
        load_block(m_rnd, 1, 1'b0);
        emit_block(e_rnd, -1, 1'b0, 1'b0, -1, got);

        for (int i = 0; i < 16; i++) m_rnd[i] = $urandom;
        e_rnd = ref_sched(m_rnd);
        load_block(m_rnd, 0, 1'b1);
        emit_block(e_rnd, -1, 1'b0, 1'b1, -1, got);

        for (int i = 0; i < 16; i++) m_rnd[i] = $urandom;
        load_block(m_rnd, 2, 1'b0);
        emit_block(ref_sched(m_rnd), -1, 1'b0, 1'b0, 30, got);
        load_block(m_abc, 0, 1'b0);
        emit_block(e_abc, -1, 1'b0, 1'b0, -1, got);
        chk("post_abort_W16", got[16], 32'h61626380);
        chk("post_abort_W17", got[17], 32'h000F0000);

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++) m_rnd[i] = $urandom;
            e_rnd = ref_sched(m_rnd);
            load_block(m_rnd, 2, 1'b0);
            emit_block(e_rnd, int'($urandom_range(0, 63)), 1'b1, 1'b0, -1, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 Parameter ROUNDS, default 64, number of schedule words emitted per block; only 64 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a block; sampled only in IDLE.
REQ-005 in_valid  input  1  in_word carries a message word.
REQ-006 in_ready  output  1  block accepts a message word this cycle.
REQ-007 in_word  input  32  message word M[i], big-endian word order, i = 0..15.
REQ-008 out_valid  output  1  out_word/out_idx carry schedule word W[t].
REQ-009 out_ready  input  1  consumer accepts W[t] this cycle.
REQ-010 out_word  output  32  schedule word W[t].
REQ-011 out_idx  output  6  round index t, 0..63.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse after W[63] is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, EMIT, DONE.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 -> LOAD with word counter cleared to 0.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready handshake writes in_word to buf[cnt] and increments cnt; the handshake at cnt=15 -> EMIT with t=0.
REQ-017 Gaps in in_valid SHALL stall LOAD without losing or duplicating words.
REQ-018 EMIT: out_valid=1; out_idx=t; for t<16, out_word=buf[t].
REQ-019 For t>=16, out_word = ls1(buf[(t-2)%16]) + buf[(t-7)%16] + ls0(buf[(t-15)%16]) + buf[(t-16)%16], mod 2^32, where ls0 = ROTR7^ROTR18^SHR3 and ls1 = ROTR17^ROTR19^SHR10.
REQ-020 On an out_valid&out_ready handshake with t>=16, out_word SHALL be written to buf[t%16], reading the old W[t-16] in the same cycle; then t increments.
REQ-021 While out_valid=1 and out_ready=0, out_word and out_idx SHALL hold stable and the buffer SHALL NOT change.
REQ-022 First W[0] SHALL appear one cycle after the 16th input handshake; sustained throughput is one word per cycle with out_ready=1.
REQ-023 A handshake at t=63 -> DONE; DONE asserts done for exactly one cycle, then returns to IDLE.
REQ-024 start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-025 out_word SHALL be 0 whenever out_valid=0.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, cnt=0, t=0, in_ready=0, out_valid=0, out_idx=0, out_word=0, busy=0, done=0, regardless of the current state.
REQ-027 Buffer contents need not reset, and no output SHALL depend on them before 16 new words are loaded.
REQ-028 After rst_n deasserts mid-block, the next start SHALL begin a fresh block with no residue from the aborted block.

Structure
REQ-029 Shared package sha256_pkg SHALL hold the state enum, the WORDS=16 and ROUNDS=64 constants, and the 32-bit word typedef.
REQ-030 The sigma functions SHALL be the existing low_sigma_0_func and low_sigma_1_func instances; no other sub-module is required.
REQ-031 The buffer SHALL be a 16x32 register array addressed modulo 16; there SHALL be no 64-entry storage.

Verification
REQ-032 "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), out_ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, with all 64 words matching a reference model.
REQ-033 All-zero block -> 64 outputs of 0x00000000, out_idx 0..63 in order, then a single done pulse.
REQ-034 out_ready held low for 3 cycles at t=20 -> out_word/out_idx are constant across the stall, and the W sequence is identical to the unstalled run.
REQ-035 in_valid toggled 1/0 during LOAD -> exactly 16 words captured and W0..W15 equal M0..M15.
REQ-036 rst_n asserted at t=30 -> out_valid=0 and busy=0 without waiting for a clock edge; a new start plus the "abc" block reproduces the REQ-032 values.
REQ-037 start pulsed during LOAD and during EMIT -> no state change and no restart.
